// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline-stage types and constants.
package mips_pkg;
    typedef enum logic {RUN, WAIT} stage_state_t;
    localparam int ALUOP_W = 3;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
    } ex_ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load in EX.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rt_i,
    input  logic             id_valid_i,
    output logic             hz_o
);
    assign hz_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != REG_W'(REG_ZERO)) & id_valid_i &
                  ((ex_rd_i == id_rs_i) | (id_use_rt_i & (ex_rd_i == id_rt_i)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion, flush and hold.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   ID_Rs,
    input  logic [REG_W-1:0]   ID_Rt,
    input  logic [REG_W-1:0]   ID_Rd,
    input  logic               ID_useRt,
    input  logic               ID_regDst,
    input  logic               ID_regWrite,
    input  logic               ID_memRead,
    input  logic               ID_memWrite,
    input  logic               ID_memToReg,
    input  logic               ID_aluSrc,
    input  logic [ALUOP_W-1:0] ID_aluOp,
    input  logic [DATA_W-1:0]  ID_readData1,
    input  logic [DATA_W-1:0]  ID_readData2,
    input  logic [DATA_W-1:0]  ID_imm,
    input  logic               ID_valid,
    input  logic               flush,
    input  logic               hold,
    output logic [REG_W-1:0]   EX_Rs,
    output logic [REG_W-1:0]   EX_Rt,
    output logic [REG_W-1:0]   EX_Rd,
    output logic               EX_regWrite,
    output logic               EX_memRead,
    output logic               EX_memWrite,
    output logic               EX_memToReg,
    output logic               EX_aluSrc,
    output logic [ALUOP_W-1:0] EX_aluOp,
    output logic [DATA_W-1:0]  EX_readData1,
    output logic [DATA_W-1:0]  EX_readData2,
    output logic [DATA_W-1:0]  EX_imm,
    output logic               EX_valid,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        ex_ctrl_t          ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic              valid;
    } ex_t;

    stage_state_t     state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    ex_t              ex_q, ex_d, ex_ld;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, stall_cnt_inc;
    logic             hz;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .ex_valid_i   (ex_q.valid),
        .ex_mem_read_i(ex_q.ctrl.memRead),
        .ex_rd_i      (ex_q.rd),
        .id_rs_i      (ID_Rs),
        .id_rt_i      (ID_Rt),
        .id_use_rt_i  (ID_useRt),
        .id_valid_i   (ID_valid),
        .hz_o         (hz)
    );

    assign ex_ld = {ID_Rs, ID_Rt, ID_regDst ? ID_Rd : ID_Rt,
                    ID_regWrite, ID_memRead, ID_memWrite, ID_memToReg, ID_aluSrc, ID_aluOp,
                    ID_readData1, ID_readData2, ID_imm, ID_valid};
    assign stall_cnt_inc = &stall_cnt_q ? stall_cnt_q : stall_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
            ex_d    = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (state_q == WAIT) begin
            ex_d        = '0;
            stall_cnt_d = stall_cnt_inc;
            cnt_d       = cnt_q - 2'd1;
            state_d     = (cnt_q == 2'd1) ? RUN : WAIT;
        end else if (hz) begin
            ex_d        = '0;
            stall_cnt_d = stall_cnt_inc;
            state_d     = (LOAD_LAT > 1) ? WAIT : RUN;
            cnt_d       = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 1) : 2'd0;
        end else begin
            ex_d = ex_ld;
        end
    end

    assign stall = ~flush & (hold | ((state_q == RUN) & hz) | (state_q == WAIT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign EX_Rs        = ex_q.rs;
    assign EX_Rt        = ex_q.rt;
    assign EX_Rd        = ex_q.rd;
    assign EX_regWrite  = ex_q.ctrl.regWrite;
    assign EX_memRead   = ex_q.ctrl.memRead;
    assign EX_memWrite  = ex_q.ctrl.memWrite;
    assign EX_memToReg  = ex_q.ctrl.memToReg;
    assign EX_aluSrc    = ex_q.ctrl.aluSrc;
    assign EX_aluOp     = ex_q.ctrl.aluOp;
    assign EX_readData1 = ex_q.rd1;
    assign EX_readData2 = ex_q.rd2;
    assign EX_imm       = ex_q.imm;
    assign EX_valid     = ex_q.valid;
    assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of id_ex_stage with LOAD_LAT=1 (u1) and LOAD_LAT=3 (u3).
module tb_id_ex_stage;
    logic        clk = 0;
    logic        rst;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_useRt, ID_regDst, ID_regWrite, ID_memRead, ID_memWrite, ID_memToReg, ID_aluSrc;
    logic [2:0]  ID_aluOp;
    logic [31:0] ID_readData1, ID_readData2, ID_imm;
    logic        ID_valid, flush, hold;

    logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic        a_rw, a_mr, a_mw, a_mtr, a_as, a_v, a_st;
    logic        b_rw, b_mr, b_mw, b_mtr, b_as, b_v, b_st;
    logic [2:0]  a_op, b_op;
    logic [31:0] a_d1, a_d2, a_im, b_d1, b_d2, b_im;
    logic [15:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.LOAD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_useRt(ID_useRt),
        .ID_regDst(ID_regDst), .ID_regWrite(ID_regWrite), .ID_memRead(ID_memRead),
        .ID_memWrite(ID_memWrite), .ID_memToReg(ID_memToReg), .ID_aluSrc(ID_aluSrc),
        .ID_aluOp(ID_aluOp), .ID_readData1(ID_readData1), .ID_readData2(ID_readData2),
        .ID_imm(ID_imm), .ID_valid(ID_valid), .flush(flush), .hold(hold),
        .EX_Rs(a_rs), .EX_Rt(a_rt), .EX_Rd(a_rd), .EX_regWrite(a_rw), .EX_memRead(a_mr),
        .EX_memWrite(a_mw), .EX_memToReg(a_mtr), .EX_aluSrc(a_as), .EX_aluOp(a_op),
        .EX_readData1(a_d1), .EX_readData2(a_d2), .EX_imm(a_im), .EX_valid(a_v),
        .stall(a_st), .stall_cnt(a_cnt)
    );

    id_ex_stage #(.LOAD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_useRt(ID_useRt),
        .ID_regDst(ID_regDst), .ID_regWrite(ID_regWrite), .ID_memRead(ID_memRead),
        .ID_memWrite(ID_memWrite), .ID_memToReg(ID_memToReg), .ID_aluSrc(ID_aluSrc),
        .ID_aluOp(ID_aluOp), .ID_readData1(ID_readData1), .ID_readData2(ID_readData2),
        .ID_imm(ID_imm), .ID_valid(ID_valid), .flush(flush), .hold(hold),
        .EX_Rs(b_rs), .EX_Rt(b_rt), .EX_Rd(b_rd), .EX_regWrite(b_rw), .EX_memRead(b_mr),
        .EX_memWrite(b_mw), .EX_memToReg(b_mtr), .EX_aluSrc(b_as), .EX_aluOp(b_op),
        .EX_readData1(b_d1), .EX_readData2(b_d2), .EX_imm(b_im), .EX_valid(b_v),
        .stall(b_st), .stall_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic use_rt, input logic reg_dst, input logic mem_read);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_useRt = use_rt; ID_regDst = reg_dst;
        ID_regWrite = 1; ID_memRead = mem_read; ID_memWrite = 0; ID_memToReg = mem_read;
        ID_aluSrc = mem_read; ID_aluOp = mem_read ? 3'd0 : 3'd2;
        ID_readData1 = 32'h1000 + 32'(rs); ID_readData2 = 32'h2000 + 32'(rt);
        ID_imm = 32'h30 + 32'(rd); ID_valid = 1;
    endtask

    task automatic do_reset();
        rst = 0; flush = 0; hold = 0;
        {ID_Rs, ID_Rt, ID_Rd} = 15'($urandom);
        {ID_useRt, ID_regDst, ID_regWrite, ID_memRead, ID_memWrite, ID_memToReg, ID_aluSrc} = 7'($urandom);
        ID_aluOp = 3'($urandom); ID_valid = 1'($urandom);
        ID_readData1 = $urandom; ID_readData2 = $urandom; ID_imm = $urandom;
        cyc();
        cyc();
    endtask

    task automatic lw(input logic [4:0] rt);
        rst = 1;
        drive(5'd2, rt, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
    endtask

    initial begin
        do_reset();
        check("rst_u1_valid", a_v, 0);
        check("rst_u1_rd", a_rd, 0);
        check("rst_u1_rw", a_rw, 0);
        check("rst_u1_d1", a_d1, 0);
        check("rst_u1_stall", a_st, 0);
        check("rst_u1_cnt", a_cnt, 0);
        check("rst_u3_valid", b_v, 0);
        check("rst_u3_imm", b_im, 0);
        check("rst_u3_stall", b_st, 0);
        check("rst_u3_cnt", b_cnt, 0);

        rst = 1;
        drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc();
        check("norm_rd", a_rd, 5);
        check("norm_rs", a_rs, 3);
        check("norm_rw", a_rw, 1);
        check("norm_valid", a_v, 1);
        check("norm_d1", a_d1, 32'h1003);
        check("norm_op", a_op, 2);
        check("norm_stall", a_st, 0);
        drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        check("norm_rd_rt", b_rd, 4);
        hold = 1;
        drive(5'd6, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        check("hold_stall", a_st, 1);
        cyc();
        check("hold_rd", a_rd, 4);
        check("hold_rs", a_rs, 3);
        hold = 0;

        do_reset();
        lw(5'd8);
        check("lw_mr", a_mr, 1);
        check("lw_rd", a_rd, 8);
        drive(5'd2, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_u1_stall0", a_st, 1);
        check("lu_u3_stall0", b_st, 1);
        cyc();
        check("lu_u1_bub_rd", a_rd, 0);
        check("lu_u1_bub_rw", a_rw, 0);
        check("lu_u1_bub_v", a_v, 0);
        check("lu_u1_stall1", a_st, 0);
        check("lu_u1_cnt", a_cnt, 1);
        check("lu_u3_stall1", b_st, 1);
        cyc();
        check("lu_u1_add_rd", a_rd, 10);
        check("lu_u1_add_v", a_v, 1);
        check("lu_u3_stall2", b_st, 1);
        check("lu_u3_bub_v", b_v, 0);
        cyc();
        check("lu_u3_stall3", b_st, 0);
        check("lu_u3_cnt", b_cnt, 3);
        check("lu_u3_bub_rd", b_rd, 0);
        cyc();
        check("lu_u3_add_rd", b_rd, 10);
        check("lu_u3_add_rw", b_rw, 1);

        do_reset();
        lw(5'd8);
        drive(5'd2, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0);
        #1;
        check("nort_u1_stall", a_st, 0);
        check("nort_u3_stall", b_st, 0);
        cyc();
        check("nort_u3_rd", b_rd, 10);
        check("nort_u3_cnt", b_cnt, 0);

        do_reset();
        lw(5'd8);
        drive(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0);
        cyc();
        cyc();
        flush = 1;
        #1;
        check("fl_stall", b_st, 0);
        cyc();
        flush = 0;
        #1;
        check("fl_bub_v", b_v, 0);
        check("fl_bub_rd", b_rd, 0);
        check("fl_cnt", b_cnt, 2);
        check("fl_run_stall", b_st, 0);
        cyc();
        check("fl_add_rd", b_rd, 10);

        do_reset();
        lw(5'd8);
        drive(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0);
        cyc();
        hold = 1;
        for (int i = 0; i < 4; i++) cyc();
        check("hw_stall", b_st, 1);
        check("hw_cnt", b_cnt, 1);
        check("hw_v", b_v, 0);
        hold = 0;
        #1;
        check("hw_res_stall0", b_st, 1);
        cyc();
        check("hw_res_stall1", b_st, 1);
        check("hw_res_cnt1", b_cnt, 2);
        cyc();
        check("hw_res_stall2", b_st, 0);
        check("hw_res_cnt2", b_cnt, 3);
        cyc();
        check("hw_add_rd", b_rd, 10);

        do_reset();
        lw(5'd0);
        drive(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
        #1;
        check("z_u1_stall", a_st, 0);
        check("z_u3_stall", b_st, 0);
        cyc();
        check("z_u3_rd", b_rd, 10);
        check("z_u3_cnt", b_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
